// File: rtl/alu_exec_unit_pkg.sv
// Shared decode constants, internal opcode/state types and the ALUOp/func decoder
// used by the EX-stage ALU execute unit.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] FUNC_SLL   = 6'b000000;
  localparam logic [5:0] FUNC_SRL   = 6'b000010;
  localparam logic [5:0] FUNC_SRA   = 6'b000011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_ADDU  = 6'b100001;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_SUBU  = 6'b100011;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;

  // Legacy 4-bit control codes are preserved; new operations fill the free codes.
  typedef enum logic [3:0] {
    OPC_AND    = 4'b0000,
    OPC_OR     = 4'b0001,
    OPC_ADD    = 4'b0010,
    OPC_XOR    = 4'b0011,
    OPC_ADDU   = 4'b0100,
    OPC_SUBU   = 4'b0101,
    OPC_SUB    = 4'b0110,
    OPC_SLT    = 4'b0111,
    OPC_SLTU   = 4'b1000,
    OPC_SLL    = 4'b1001,
    OPC_SRL    = 4'b1010,
    OPC_SRA    = 4'b1011,
    OPC_NOR    = 4'b1100,
    OPC_MFHI   = 4'b1101,
    OPC_MFLO   = 4'b1110,
    OPC_MULDIV = 4'b1111
  } alu_opc_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    alu_opc_e opc;
    md_op_e   md;
    logic     illegal;
  } dec_t;

  function automatic dec_t decode_op(input logic [1:0] alu_op, input logic [5:0] func,
                                     input logic md_en);
    dec_t d;
    d.opc     = OPC_AND;
    d.md      = MD_MULT;
    d.illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: d.opc = OPC_ADD;
      ALUOP_SUB: d.opc = OPC_SUB;
      ALUOP_RTYPE: begin
        case (func)
          FUNC_ADD:   d.opc = OPC_ADD;
          FUNC_ADDU:  d.opc = OPC_ADDU;
          FUNC_SUB:   d.opc = OPC_SUB;
          FUNC_SUBU:  d.opc = OPC_SUBU;
          FUNC_AND:   d.opc = OPC_AND;
          FUNC_OR:    d.opc = OPC_OR;
          FUNC_XOR:   d.opc = OPC_XOR;
          FUNC_NOR:   d.opc = OPC_NOR;
          FUNC_SLT:   d.opc = OPC_SLT;
          FUNC_SLTU:  d.opc = OPC_SLTU;
          FUNC_SLL:   d.opc = OPC_SLL;
          FUNC_SRL:   d.opc = OPC_SRL;
          FUNC_SRA:   d.opc = OPC_SRA;
          FUNC_MFHI:  begin d.opc = OPC_MFHI;   d.illegal = !md_en; end
          FUNC_MFLO:  begin d.opc = OPC_MFLO;   d.illegal = !md_en; end
          FUNC_MULT:  begin d.opc = OPC_MULDIV; d.md = MD_MULT;  d.illegal = !md_en; end
          FUNC_MULTU: begin d.opc = OPC_MULDIV; d.md = MD_MULTU; d.illegal = !md_en; end
          FUNC_DIV:   begin d.opc = OPC_MULDIV; d.md = MD_DIV;   d.illegal = !md_en; end
          FUNC_DIVU:  begin d.opc = OPC_MULDIV; d.md = MD_DIVU;  d.illegal = !md_en; end
          default:    d.illegal = 1'b1;
        endcase
      end
      ALUOP_ILL: d.illegal = 1'b1;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID operand latch and the ALU execute unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [5:0]         func;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;
  logic               illegal;
  logic               div_by_zero;
  logic               busy;

  modport master (
    output in_valid, alu_op, func, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, div_by_zero, busy
  );

  modport slave (
    input  in_valid, alu_op, func, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, div_by_zero, busy
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative one-bit-per-cycle multiply (shift-add) and restoring divide on magnitudes,
// with sign correction applied combinationally on the final hi/lo.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             r_run;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? (~i_a + {{(WIDTH-1){1'b0}}, 1'b1}) : i_a;
  assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? (~i_b + {{(WIDTH-1){1'b0}}, 1'b1}) : i_b;

  // Multiply accumulates into the upper half and shifts right; divide shifts the
  // dividend left into the remainder, so both reuse the same acc/lo pair.
  assign w_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_rsh = {r_acc, r_lo[WIDTH-1]};
  assign w_dif = w_rsh - {1'b0, r_b};

  assign w_prod_neg = ~{r_acc, r_lo} + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign o_done     = r_run && (r_cnt == {CNT_W{1'b0}});

  // Signed results: quotient/product take sign(a)^sign(b), remainder takes sign(a).
  always_comb begin
    o_hi = r_acc;
    o_lo = r_lo;
    if (r_div) begin
      o_lo = r_neg_q ? (~r_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : r_lo;
      o_hi = r_neg_r ? (~r_acc + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc;
    end else begin
      o_hi = r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc;
      o_lo = r_neg_q ? w_prod_neg[WIDTH-1:0] : r_lo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_div   <= i_is_div;
      r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r <= i_signed && i_a[WIDTH-1];
      r_cnt   <= CNT_W'(WIDTH-1);
      r_acc   <= {WIDTH{1'b0}};
      r_lo    <= w_a_mag;
      r_b     <= w_b_mag;
    end else if (r_run) begin
      if (r_cnt == {CNT_W{1'b0}}) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_div) begin
        r_acc <= w_dif[WIDTH] ? w_rsh[WIDTH-1:0] : w_dif[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], !w_dif[WIDTH]};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/func, runs single-cycle ops directly and mult/div through
// the iterative sequencer, and returns a registered result over valid/ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic             r_divz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  dec_t             w_dec;
  logic [SHAMT_W-1:0] w_sh;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_fin;
  logic             w_acc;
  logic             w_is_md;
  logic             w_is_div;
  logic             w_md_signed;
  logic             w_divz;
  logic             w_md_start;
  logic             w_simple;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;

  assign w_sh  = bus.shamt;
  assign w_sum = bus.op_a + bus.op_b;
  assign w_dif = bus.op_a - bus.op_b;

  // Decode and single-cycle execute.
  always_comb begin
    w_dec = decode_op(bus.alu_op, bus.func, MULDIV_EN);
    w_res = {WIDTH{1'b0}};
    w_ovf = 1'b0;
    case (w_dec.opc)
      OPC_AND:  w_res = bus.op_a & bus.op_b;
      OPC_OR:   w_res = bus.op_a | bus.op_b;
      OPC_XOR:  w_res = bus.op_a ^ bus.op_b;
      OPC_NOR:  w_res = ~(bus.op_a | bus.op_b);
      OPC_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OPC_SUB: begin
        w_res = w_dif;
        w_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OPC_ADDU: w_res = w_sum;
      OPC_SUBU: w_res = w_dif;
      OPC_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OPC_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      OPC_SLL:  w_res = bus.op_b << w_sh;
      OPC_SRL:  w_res = bus.op_b >> w_sh;
      OPC_SRA:  w_res = $unsigned($signed(bus.op_b) >>> w_sh);
      OPC_MFHI: w_res = r_hi;
      OPC_MFLO: w_res = r_lo;
      // Only reaches the result register for the divide-by-zero shortcut (LO = all ones).
      OPC_MULDIV: w_res = {WIDTH{1'b1}};
      default:  w_res = {WIDTH{1'b0}};
    endcase
  end

  assign w_res_fin   = w_dec.illegal ? {WIDTH{1'b0}} : w_res;
  assign w_acc       = bus.in_valid && bus.in_ready;
  assign w_is_md     = !w_dec.illegal && (w_dec.opc == OPC_MULDIV);
  assign w_is_div    = (w_dec.md == MD_DIV) || (w_dec.md == MD_DIVU);
  assign w_md_signed = (w_dec.md == MD_MULT) || (w_dec.md == MD_DIV);
  assign w_divz      = w_is_md && w_is_div && (bus.op_b == {WIDTH{1'b0}});
  assign w_md_start  = w_acc && w_is_md && !w_divz;
  assign w_simple    = w_acc && !(w_is_md && !w_divz);

  alu_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (w_md_start),
    .i_is_div (w_is_div),
    .i_signed (w_md_signed),
    .i_a      (bus.op_a),
    .i_b      (bus.op_b),
    .o_done   (w_md_done),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_md_start) begin
          w_state_nxt = w_is_div ? ST_DIV : ST_MUL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_md_done) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result/flag registers and the architectural HI/LO pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_divz      <= 1'b0;
      r_hi        <= {WIDTH{1'b0}};
      r_lo        <= {WIDTH{1'b0}};
    end else if (w_simple) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res_fin;
      r_zero      <= (w_res_fin == {WIDTH{1'b0}});
      r_ovf       <= w_ovf && !w_dec.illegal;
      r_illegal   <= w_dec.illegal;
      r_divz      <= w_divz;
      if (w_divz) begin
        r_hi <= bus.op_a;
        r_lo <= {WIDTH{1'b1}};
      end
    end else if (r_state == ST_DONE) begin
      r_out_valid <= 1'b1;
      r_result    <= w_md_lo;
      r_zero      <= (w_md_lo == {WIDTH{1'b0}});
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_divz      <= 1'b0;
      r_hi        <= w_md_hi;
      r_lo        <= w_md_lo;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.zero        = r_zero;
  assign bus.overflow    = r_ovf;
  assign bus.illegal     = r_illegal;
  assign bus.div_by_zero = r_divz;
  assign bus.busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: table of single-cycle vectors plus hand-written
// mult/div, backpressure and mid-operation reset sequences.
module tb_alu_exec_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_exec_unit_if #(.WIDTH(32)) bus();

  alu_exec_unit #(
    .WIDTH(32),
    .MULDIV_EN(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    logic        zr;
  } vec_t;

  vec_t vecs[18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
    int n;
    n = 0;
    bus.alu_op   = op;
    bus.func     = fn;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, returning cycles waited and cycles busy was seen high.
  task automatic wait_valid(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 6'b100001, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 6'b101011, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b10, 6'b000011, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2'b00, 6'b000000, 32'h00000005, 32'h00000003, 5'd0,  32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 6'b000000, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'b100011, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 6'b100110, 32'hAAAA5555, 32'hFFFF0000, 5'd0,  32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b10, 6'b100111, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 6'b000000, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b10, 6'b000010, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{2'b11, 6'b100000, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{2'b10, 6'b100010, 32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{2'b10, 6'b100000, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.func      = 6'b000000;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.shamt     = 5'd0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_flags", {29'd0, bus.overflow, bus.illegal, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sh);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
      chk($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].zr));
    end

    // mult -3 * 7
    send(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h00000007, 5'd0);
    chk("mult_in_ready_busy", 32'(bus.in_ready), 32'd0);
    wait_valid(n, nb);
    chk("mult_latency", 32'(n), 32'd33);
    chk("mult_busy_cycles", 32'(nb), 32'd33);
    chk("mult_lo", bus.result, 32'hFFFFFFEB);
    chk("mult_ovf", 32'(bus.overflow), 32'd0);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("mult_mfhi", bus.result, 32'hFFFFFFFF);

    // multu max * max
    send(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    wait_valid(n, nb);
    chk("multu_lo", bus.result, 32'h00000001);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("multu_mfhi", bus.result, 32'hFFFFFFFE);

    // div -7 / 2
    send(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h00000002, 5'd0);
    wait_valid(n, nb);
    chk("div_latency", 32'(n), 32'd33);
    chk("div_lo", bus.result, 32'hFFFFFFFD);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("div_mfhi", bus.result, 32'hFFFFFFFF);

    // divu 100 / 7
    send(2'b10, 6'b011011, 32'd100, 32'd7, 5'd0);
    wait_valid(n, nb);
    chk("divu_lo", bus.result, 32'd14);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("divu_mfhi", bus.result, 32'd2);

    // signed MIN / -1
    send(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_valid(n, nb);
    chk("divmin_lo", bus.result, 32'h80000000);
    chk("divmin_ovf", 32'(bus.overflow), 32'd0);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("divmin_mfhi", bus.result, 32'h0);

    // divu by zero
    send(2'b10, 6'b011011, 32'h00001234, 32'h00000000, 5'd0);
    chk("divz_valid", 32'(bus.out_valid), 32'd1);
    chk("divz_flag", 32'(bus.div_by_zero), 32'd1);
    chk("divz_busy", 32'(bus.busy), 32'd0);
    chk("divz_lo", bus.result, 32'hFFFFFFFF);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("divz_mfhi", bus.result, 32'h00001234);
    chk("divz_flag_clear", 32'(bus.div_by_zero), 32'd0);

    // Backpressure: hold a result for 5 cycles with another request waiting.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(2'b10, 6'b100000, 32'd2, 32'd2, 5'd0);
    bus.alu_op   = 2'b10;
    bus.func     = 6'b100010;
    bus.op_a     = 32'd9;
    bus.op_b     = 32'd1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d_result", k), bus.result, 32'd4);
      chk($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd1);
    chk("release_result", bus.result, 32'd8);

    // Reset in the middle of a multiply.
    send(2'b10, 6'b011000, 32'd6, 32'd7, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b10, 6'b010000, 32'h0, 32'h0, 5'd0);
    chk("midrst_hi", bus.result, 32'h0);
    send(2'b10, 6'b010010, 32'h0, 32'h0, 5'd0);
    chk("midrst_lo", bus.result, 32'h0);
    send(2'b10, 6'b011000, 32'd6, 32'd7, 5'd0);
    wait_valid(n, nb);
    chk("postrst_mult_latency", 32'(n), 32'd33);
    chk("postrst_mult", bus.result, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
